// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with a per-register scoreboard
//               for the pipelined RV32 core.  Decode reads operands
//               combinationally, claims destination registers on issue,
//               and is stalled on RAW/WAW hazards.  Writeback writes data
//               and releases the claim.  A flush clears all claims.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a read matching the active writeback returns wb_data in the
//               same cycle and its rd_busy reads 0 (RAW resolves in the
//               writeback cycle)
//   undefined - reads return stored contents; rd_busy drops after the
//               clearing edge
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   rd_addr    in   NRD*AW  packed read addresses (port k at [k*AW +: AW])
//   rd_use     in   NRD     port k operand is used by the decoded instruction
//   rd_data    out  NRD*XLEN packed read data
//   rd_busy    out  NRD     port k register has a pending writeback
//   iss_valid  in   decode requests issue
//   iss_we     in   issuing instruction writes a destination register
//   iss_rd     in   AW      destination register of the issuing instruction
//   iss_ready  out  issue accepted this cycle
//   wb_valid   in   writeback strobe
//   wb_addr    in   AW      writeback register
//   wb_data    in   XLEN    writeback value
//   flush      in   pipeline flush, clears every busy bit
//   busy_vec   out  NREGS   scoreboard state
// ============================================================================
`default_nettype none

module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   input  logic [NRD-1:0]      rd_use,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_valid,
   input  logic                iss_we,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);

   localparam logic [AW-1:0] c_x0      = '0;
   localparam logic          c_zero_en = (ZERO_REG != 0);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [NRD-1:0]   w_rd_busy;
   logic             w_wb_en;
   logic             w_raw;
   logic             w_waw;
   logic             w_iss_zero;

   // Writes to x0 are dropped when it is hardwired to zero.
   assign w_wb_en    = wb_valid & ~(c_zero_en & (wb_addr == c_x0));
   assign w_iss_zero = c_zero_en & (iss_rd == c_x0);

   // ------------------------------------------------------------------------
   // Register storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_en) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < NRD; k++) begin : g_rd
         logic [AW-1:0] w_addr;
         logic          w_zero;
         logic          w_hit;

         assign w_addr = rd_addr[k*AW +: AW];
         assign w_zero = c_zero_en & (w_addr == c_x0);
`ifdef REGFILE_BYPASS_EN
         // w_wb_en already excludes a hardwired x0, so no bypass onto it.
         assign w_hit  = w_wb_en & (wb_addr == w_addr);
`else
         assign w_hit  = 1'b0;
`endif
         // A forwarded operand is no longer a hazard for this port.
         assign w_rd_busy[k] = r_busy[w_addr] & ~w_hit;

         // Outputs are forced to zero while reset is held so that a bypassed
         // wb_data cannot leak out during reset.
         assign rd_data[k*XLEN +: XLEN] = (rst | w_zero) ? '0 :
                                          (w_hit ? wb_data : r_regs[w_addr]);
      end
   endgenerate

   assign rd_busy = rst ? '0 : w_rd_busy;

   // ------------------------------------------------------------------------
   // Issue handshake
   // ------------------------------------------------------------------------
   assign w_raw = |(rd_use & w_rd_busy);
   assign w_waw = iss_we & r_busy[iss_rd];

   assign iss_ready = iss_valid & ~flush & ~rst & ~w_raw & ~w_waw;

   // ------------------------------------------------------------------------
   // Scoreboard update: flush over everything; otherwise writeback release
   // first, then issue claim, so a same-cycle claim of the register being
   // written back leaves it busy for the new producer.
   // ------------------------------------------------------------------------
   always_comb begin
      w_busy_nxt = r_busy;
      if (flush) begin
         w_busy_nxt = '0;
      end else begin
         if (wb_valid) begin
            w_busy_nxt[wb_addr] = 1'b0;
         end
         if (iss_ready & iss_we & ~w_iss_zero) begin
            w_busy_nxt[iss_rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb (XLEN=32,
//               NREGS=32, NRD=2, ZERO_REG=1).  Expectations follow the
//               REGFILE_BYPASS_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic                clk;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD-1:0]      rd_use;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_valid;
   logic                iss_we;
   logic [AW-1:0]       iss_rd;
   logic                iss_ready;
   logic                wb_valid;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                flush;
   logic [NREGS-1:0]    busy_vec;

   int checks   = 0;
   int failures = 0;

   regfile_sb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .AW       (AW),
      .NRD      (NRD),
      .ZERO_REG (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_use    (rd_use),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .iss_valid (iss_valid),
      .iss_we    (iss_we),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flush     (flush),
      .busy_vec  (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 0; iss_we = 0; iss_rd = '0; rd_use = '0;
      wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      iss_valid = 1; iss_we = 1; iss_rd = rd;
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [31:0] d);
      wb_valid = 1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      rst = 1;
      idle();
      set_rd(5'd5, 5'd0);

      // ---- Reset state -------------------------------------------------
      iss_valid = 1;
      #3;
      check("reset_rd0", rd_data[31:0], 32'h0);
      check("reset_busy_vec", busy_vec, 32'h0);
      check("reset_iss_ready", {31'b0, iss_ready}, 32'h0);
      #9 rst = 0;             // t=12, first usable edge at t=15
      idle();

      // ---- 1. Reset mid-operation --------------------------------------
      wb(5'd5, 32'hDEADBEEF);
      issue(5'd7);
      #1;
      check("t1_iss_ready", {31'b0, iss_ready}, 32'h1);
      tick();
      idle();
      #1;
      check("t1_x5_written", rd_data[31:0], 32'hDEADBEEF);
      check("t1_busy_x7", busy_vec, 32'h0000_0080);
      rst = 1;
      iss_valid = 1;
      #1;
      check("t1_async_rd_x5", rd_data[31:0], 32'h0);
      check("t1_async_busy", busy_vec, 32'h0);
      check("t1_async_ready", {31'b0, iss_ready}, 32'h0);
      #2 rst = 0;
      idle();
      #1;
      check("t1_post_rst_x5", rd_data[31:0], 32'h0);

      // ---- 2. x0 protection --------------------------------------------
      tick();
      wb(5'd0, 32'hFFFFFFFF);
      issue(5'd0);
      tick();
      idle();
      set_rd(5'd0, 5'd0);
      #1;
      check("t2_x0_read", rd_data[31:0], 32'h0);
      check("t2_busy_vec", busy_vec, 32'h0);

      // ---- 3. RAW stall ------------------------------------------------
      tick();
      issue(5'd3);
      tick();
      iss_rd = 5'd10;          // reader of x3 that writes x10
      set_rd(5'd3, 5'd0);
      rd_use = 2'b01;
      #1;
      check("t3_raw_stall0", {31'b0, iss_ready}, 32'h0);
      check("t3_rd_busy", {30'b0, rd_busy}, 32'h1);
      tick();
      check("t3_raw_stall1", {31'b0, iss_ready}, 32'h0);
      wb(5'd3, 32'h12345678);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("t3_wb_cycle_ready", {31'b0, iss_ready}, 32'h1);
      check("t3_wb_cycle_data", rd_data[31:0], 32'h12345678);
      tick();
      idle();
`else
      check("t3_wb_cycle_ready", {31'b0, iss_ready}, 32'h0);
      check("t3_wb_cycle_data", rd_data[31:0], 32'h0);
      tick();
      wb_valid = 0;
      #1;
      check("t3_next_ready", {31'b0, iss_ready}, 32'h1);
      check("t3_next_data", rd_data[31:0], 32'h12345678);
      tick();
      idle();
`endif
      #1;
      check("t3_busy_x10", busy_vec, 32'h0000_0400);
      wb(5'd10, 32'h0);
      tick();
      idle();
      #1;
      check("t3_clean", busy_vec, 32'h0);

      // ---- 4. Simultaneous writeback and claim --------------------------
      issue(5'd9);
      tick();
      wb(5'd9, 32'h55);        // x9 still busy: the claim is a WAW stall
      set_rd(5'd9, 5'd11);
      #1;
      check("t4_waw_on_busy", {31'b0, iss_ready}, 32'h0);
      tick();
      wb_valid = 0;
      #1;
      check("t4_x9_data", rd_data[31:0], 32'h55);
      check("t4_x9_released", busy_vec, 32'h0);
      check("t4_reclaim_ready", {31'b0, iss_ready}, 32'h1);
      tick();
      iss_rd = 5'd11;          // x11 idle: writeback and claim in one cycle
      wb(5'd11, 32'h66);
      #1;
      check("t4_same_cycle_ready", {31'b0, iss_ready}, 32'h1);
      tick();
      idle();
      #1;
      check("t4_x11_data", rd_data[63:32], 32'h66);
      check("t4_set_wins", busy_vec, 32'h0000_0A00);

      // ---- 5. WAW stall ------------------------------------------------
      issue(5'd4);
      tick();
      #1;
      check("t5_waw_stall0", {31'b0, iss_ready}, 32'h0);
      tick();
      wb(5'd4, 32'h44);
      #1;
      check("t5_waw_wb_cycle", {31'b0, iss_ready}, 32'h0);
      tick();
      wb_valid = 0;
      #1;
      check("t5_waw_accept", {31'b0, iss_ready}, 32'h1);
      tick();
      idle();
      #1;
      check("t5_busy_x4", busy_vec, 32'h0000_0A10);

      // ---- 6. Flush ----------------------------------------------------
      issue(5'd1);
      tick();
      iss_rd = 5'd2;
      tick();
      iss_rd = 5'd31;
      tick();
      idle();
      #1;
      check("t6_busy_before", busy_vec, 32'h8000_0A16);
      flush = 1;
      wb(5'd2, 32'hA5);
      issue(5'd5);
      #1;
      check("t6_flush_ready", {31'b0, iss_ready}, 32'h0);
      tick();
      idle();
      set_rd(5'd5, 5'd2);
      #1;
      check("t6_busy_cleared", busy_vec, 32'h0);
      check("t6_x2_data", rd_data[63:32], 32'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
